alu16_sequencer: RTL and testbench

- Multi-cycle front end that executes 16-bit arithmetic (ADD HL,rr / INC rr / DEC rr / ADD SP,e) by issuing two 8-bit passes to the shared 8-bit ALU.
- It is the initiator side of the ALU interface: it drives operands and opcode, samples the ALU result and flags, and chains the carry between passes.
- It sits between the CPU control FSM and the ALU, and returns a 16-bit result plus ZNHC flags with a done pulse.

---
 rtl/alu16_sequencer_if.sv | 23 ++
 rtl/alu16_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu16_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu16_sequencer_if.sv
// Bus between the 16-bit sequencer and the shared 8-bit ALU.
//   master (sequencer): drives alu_data0/alu_data1/alu_op/alu_size/alu_flags,
//                       samples alu_result/alu_flags_res
//   slave  (ALU)      : the mirror image
interface alu16_sequencer_if;
  logic [7:0] alu_data0;
  logic [7:0] alu_data1;
  logic [4:0] alu_op;
  logic       alu_size;
  logic [3:0] alu_flags;
  logic [7:0] alu_result;
  logic [3:0] alu_flags_res;

  modport master (
    output alu_data0, alu_data1, alu_op, alu_size, alu_flags,
    input  alu_result, alu_flags_res
  );

  modport slave (
    input  alu_data0, alu_data1, alu_op, alu_size, alu_flags,
    output alu_result, alu_flags_res
  );
endinterface

// File: rtl/alu16_sequencer.sv
// 16-bit arithmetic front end (ADD HL,rr / INC rr / DEC rr / ADD SP,e) built from two passes
// through the shared 8-bit ALU: low byte first, then high byte with the low-byte carry chained
// in by selecting ADC.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   start, op         : request (accepted only when idle); 0=ADD16 1=INC16 2=DEC16 3=ADDSP
//   opa, opb, flags_in: operands and current ZNHC flags, latched on accept
//   busy, done        : busy from the cycle after accept until done; done is a one-cycle pulse
//   result, flags_out : registered result and ZNHC flags, held until the next op's high pass
//   alu               : master side of the ALU bus
module alu16_sequencer #(
  parameter logic [4:0] OP_ADD = 5'd0,
  parameter logic [4:0] OP_ADC = 5'd1,
  parameter logic       SIZE_8 = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [15:0]       opa,
  input  logic [15:0]       opb,
  input  logic [3:0]        flags_in,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result,
  output logic [3:0]        flags_out,
  alu16_sequencer_if.master alu
);

  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagH = 1;
  localparam int unsigned FlagC = 0;

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;
  typedef enum logic [1:0] {OpAdd16, OpInc16, OpDec16, OpAddSp} op_e;

  state_e      state_q, state_d;
  op_e         op_q;
  logic [15:0] opa_q, opb_q;
  logic [3:0]  flags_q;
  logic [7:0]  res_lo_q;
  logic        c_lo_q, h_lo_q;
  logic [15:0] result_q;
  logic [3:0]  flags_out_q;
  logic [3:0]  flags_hi_d;

  // Z and N from the ALU are never consumed: Z comes from the latched flags, N is forced.
  logic unused_alu_zn;
  assign unused_alu_zn = ^alu.alu_flags_res[3:2];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLow;
      StLow:   state_d = StHigh;
      StHigh:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs and ALU drive
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    alu.alu_op    = OP_ADD;
    alu.alu_data0 = 8'h00;
    alu.alu_data1 = 8'h00;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StLow: begin
        busy          = 1'b1;
        alu.alu_data1 = opa_q[7:0];
        unique case (op_q)
          OpInc16: alu.alu_data0 = 8'h01;
          OpDec16: alu.alu_data0 = 8'hFF;
          default: alu.alu_data0 = opb_q[7:0];
        endcase
      end
      StHigh: begin
        busy          = 1'b1;
        alu.alu_op    = c_lo_q ? OP_ADC : OP_ADD;
        alu.alu_data1 = opa_q[15:8];
        // INC/DEC are +1/-1 as 16-bit adds of 0x0001/0xFFFF; ADDSP sign-extends e.
        unique case (op_q)
          OpAdd16: alu.alu_data0 = opb_q[15:8];
          OpInc16: alu.alu_data0 = 8'h00;
          OpDec16: alu.alu_data0 = 8'hFF;
          default: alu.alu_data0 = {8{opb_q[7]}};
        endcase
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign alu.alu_size  = SIZE_8;
  assign alu.alu_flags = flags_in;

  // Flags captured at the end of the high pass
  always_comb begin
    flags_hi_d = flags_q;
    unique case (op_q)
      OpAdd16: flags_hi_d = {flags_q[FlagZ], 1'b0, alu.alu_flags_res[FlagH],
                             alu.alu_flags_res[FlagC]};
      OpAddSp: flags_hi_d = {2'b00, h_lo_q, c_lo_q};
      default: flags_hi_d = flags_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q        <= OpAdd16;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      flags_q     <= 4'h0;
      res_lo_q    <= 8'h00;
      c_lo_q      <= 1'b0;
      h_lo_q      <= 1'b0;
      result_q    <= 16'h0000;
      flags_out_q <= 4'h0;
    end else begin
      if (state_q == StIdle && start) begin
        op_q    <= op_e'(op);
        opa_q   <= opa;
        opb_q   <= opb;
        flags_q <= flags_in;
      end
      if (state_q == StLow) begin
        res_lo_q <= alu.alu_result;
        c_lo_q   <= alu.alu_flags_res[FlagC];
        h_lo_q   <= alu.alu_flags_res[FlagH];
      end
      if (state_q == StHigh) begin
        result_q    <= {alu.alu_result, res_lo_q};
        flags_out_q <= flags_hi_d;
      end
    end
  end

  assign result    = result_q;
  assign flags_out = flags_out_q;

endmodule

// File: tb/tb_alu16_sequencer.sv
module tb_alu16_sequencer;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_ADC = 5'd1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [15:0] opa = 16'h0000;
  logic [15:0] opb = 16'h0000;
  logic [3:0]  flags_in = 4'h0;
  logic        busy, done;
  logic [15:0] result;
  logic [3:0]  flags_out;

  int errors = 0;
  int checks = 0;

  alu16_sequencer_if alu_bus ();

  alu16_sequencer #(
    .OP_ADD (OP_ADD),
    .OP_ADC (OP_ADC),
    .SIZE_8 (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags_out (flags_out),
    .alu       (alu_bus)
  );

  always #5 clock = ~clock;

  // 8-bit ALU model: ADD, or ADD with carry-in 1 for ADC; flags ZNHC.
  logic       cin;
  logic [8:0] alu_sum;
  logic [4:0] alu_half;
  always_comb begin
    cin      = (alu_bus.alu_op == OP_ADC);
    alu_sum  = {1'b0, alu_bus.alu_data0} + {1'b0, alu_bus.alu_data1} + {8'd0, cin};
    alu_half = {1'b0, alu_bus.alu_data0[3:0]} + {1'b0, alu_bus.alu_data1[3:0]} + {4'd0, cin};
  end
  assign alu_bus.alu_result    = alu_sum[7:0];
  assign alu_bus.alu_flags_res = {alu_sum[7:0] == 8'd0, 1'b0, alu_half[4], alu_sum[8]};

  // Reference: whole 16-bit arithmetic plus the expected ALU operands for each pass.
  function automatic void ref_model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] f, output logic [15:0] r,
                                    output logic [3:0] fl, output logic [7:0] d0_lo,
                                    output logic [7:0] d0_hi, output logic hi_adc);
    logic [15:0] e;
    int unsigned s;
    case (o)
      2'd0: begin
        s     = 32'(a) + 32'(b);
        r     = a + b;
        fl    = {f[3], 1'b0, (32'(a[11:0]) + 32'(b[11:0])) >= 32'h1000, s >= 32'h10000};
        d0_lo = b[7:0];
        d0_hi = b[15:8];
      end
      2'd1: begin
        r = a + 16'd1; fl = f; d0_lo = 8'h01; d0_hi = 8'h00;
      end
      2'd2: begin
        r = a - 16'd1; fl = f; d0_lo = 8'hFF; d0_hi = 8'hFF;
      end
      default: begin
        e     = {{8{b[7]}}, b[7:0]};
        r     = a + e;
        fl    = {2'b00, (32'(a[3:0]) + 32'(b[3:0])) >= 32'h10,
                 (32'(a[7:0]) + 32'(b[7:0])) >= 32'h100};
        d0_lo = b[7:0];
        d0_hi = e[15:8];
      end
    endcase
    hi_adc = (32'(a[7:0]) + 32'(d0_lo)) >= 32'h100;
  endfunction

  // Runs one op from an idle negedge; checks both ALU passes, latency and results.
  task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f);
    logic [15:0] r;
    logic [3:0]  fl;
    logic [7:0]  d0_lo, d0_hi;
    logic        hi_adc;
    ref_model(o, a, b, f, r, fl, d0_lo, d0_hi, hi_adc);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s idle busy/done got %b%b want 00", name, busy, done);
    end
    start = 1'b1; op = o; opa = a; opb = b; flags_in = f;
    @(negedge clock);  // LOW pass
    start = 1'b0; opa = 16'($urandom); opb = 16'($urandom); flags_in = 4'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || alu_bus.alu_op !== OP_ADD ||
        alu_bus.alu_data0 !== d0_lo || alu_bus.alu_data1 !== a[7:0]) begin
      errors++;
      $display("FAIL %s low pass busy=%b done=%b op=%0d d0=%h d1=%h want 1 0 %0d %h %h", name,
               busy, done, alu_bus.alu_op, alu_bus.alu_data0, alu_bus.alu_data1, OP_ADD,
               d0_lo, a[7:0]);
    end
    @(negedge clock);  // HIGH pass
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || alu_bus.alu_op !== (hi_adc ? OP_ADC : OP_ADD) ||
        alu_bus.alu_data0 !== d0_hi || alu_bus.alu_data1 !== a[15:8]) begin
      errors++;
      $display("FAIL %s high pass busy=%b done=%b op=%0d d0=%h d1=%h want 1 0 %0d %h %h", name,
               busy, done, alu_bus.alu_op, alu_bus.alu_data0, alu_bus.alu_data1,
               hi_adc ? OP_ADC : OP_ADD, d0_hi, a[15:8]);
    end
    @(negedge clock);  // DONE
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || result !== r || flags_out !== fl) begin
      errors++;
      $display("FAIL %s done=%b busy=%b result=%h flags=%b want 1 1 %h %b", name, done, busy,
               result, flags_out, r, fl);
    end
    checks++;
    if (alu_bus.alu_op !== OP_ADD || alu_bus.alu_data0 !== 8'h00 ||
        alu_bus.alu_data1 !== 8'h00) begin
      errors++;
      $display("FAIL %s done-state alu drive op=%0d d0=%h d1=%h want 0 00 00", name,
               alu_bus.alu_op, alu_bus.alu_data0, alu_bus.alu_data1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || flags_out !== 4'h0) begin
      errors++;
      $display("FAIL reset outputs busy=%b done=%b result=%h flags=%b want 0 0 0000 0000",
               busy, done, result, flags_out);
    end
    flags_in = 4'b1010;
    #1;
    checks++;
    if (alu_bus.alu_op !== OP_ADD || alu_bus.alu_data0 !== 8'h00 ||
        alu_bus.alu_data1 !== 8'h00 || alu_bus.alu_size !== 1'b0 ||
        alu_bus.alu_flags !== 4'b1010) begin
      errors++;
      $display("FAIL reset alu drive op=%0d d0=%h d1=%h size=%b flags=%b want 0 00 00 0 1010",
               alu_bus.alu_op, alu_bus.alu_data0, alu_bus.alu_data1, alu_bus.alu_size,
               alu_bus.alu_flags);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op("add16", 2'd0, 16'h8A23, 16'h0605, 4'b1000);
    run_op("inc16_carry", 2'd1, 16'h00FF, 16'h0000, 4'b0101);
    run_op("inc16_wrap", 2'd1, 16'hFFFF, 16'h1234, 4'b0101);
    run_op("dec16_wrap", 2'd2, 16'h0000, 16'h0000, 4'b1111);
    run_op("dec16_borrow", 2'd2, 16'h0100, 16'h0000, 4'b0000);
    run_op("addsp_pos", 2'd3, 16'hFFF8, 16'h0008, 4'b1111);
    run_op("addsp_neg", 2'd3, 16'h1000, 16'h00FF, 4'b1111);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'h0000;
        1:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      run_op("random", 2'($urandom), a, 16'($urandom), 4'($urandom));
    end
  endtask

  // start held high for three ADD16s; operands scrambled while busy.
  task automatic test_back_to_back();
    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic [3:0]  f_s [3];
    logic [15:0] r;
    logic [3:0]  fl;
    logic [7:0]  d0_lo, d0_hi;
    logic        hi_adc;
    for (int k = 0; k < 3; k++) begin
      a_s[k] = 16'($urandom); b_s[k] = 16'($urandom); f_s[k] = 4'($urandom);
    end
    @(negedge clock);
    op = 2'd0; start = 1'b1; opa = a_s[0]; opb = b_s[0]; flags_in = f_s[0];
    for (int k = 0; k < 3; k++) begin
      ref_model(2'd0, a_s[k], b_s[k], f_s[k], r, fl, d0_lo, d0_hi, hi_adc);
      for (int c = 0; c < 2; c++) begin
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b op%0d cycle%0d busy/done got %b%b want 10", k, c, busy, done);
        end
        opa = 16'($urandom); opb = 16'($urandom); flags_in = 4'($urandom);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || result !== r || flags_out !== fl) begin
        errors++;
        $display("FAIL b2b op%0d done=%b busy=%b result=%h flags=%b want 1 1 %h %b", k, done,
                 busy, result, flags_out, r, fl);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b op%0d idle gap busy/done got %b%b want 00", k, busy, done);
      end
      if (k < 2) begin
        opa = a_s[k+1]; opb = b_s[k+1]; flags_in = f_s[k+1];
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    run_op("pre_reset", 2'd0, 16'h8A23, 16'h0605, 4'b1000);
    @(negedge clock);
    start = 1'b1; op = 2'd0; opa = 16'h1111; opb = 16'h2222; flags_in = 4'b1000;
    @(negedge clock);  // LOW
    start = 1'b0;
    @(negedge clock);  // HIGH
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || flags_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b result=%h flags=%b want 0 0 0000 0000", busy,
               done, result, flags_out);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid cycle%0d busy/done got %b%b want 00", c, busy, done);
      end
    end
    // reset and start together: start must not be accepted
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_with_start busy got %b want 0", busy);
    end
    run_op("post_reset", 2'd3, 16'hFFF8, 16'h0008, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
